// File: rtl/hdlc_pkg.sv
// Shared HDLC receive constants and deframer state encoding.
package hdlc_pkg;
  localparam logic [7:0] FLAG  = 8'h7E;
  localparam logic [7:0] ABORT = 8'h7F;

  typedef enum logic {HUNT, FRAME} state_t;
endpackage

// File: rtl/rx_deframer_if.sv
// Serial line input and decoded byte/event outputs of the HDLC deframer.
interface rx_deframer_if;
  logic       Rx;
  logic       RxEN;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte;
  logic       Rx_ValidFrame;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_EoF;
  logic       Rx_FrameError;
  logic       ZeroDetect;

  modport master (
    output Rx, RxEN,
    input  Rx_Data, Rx_NewByte, Rx_ValidFrame, Rx_FlagDetect,
           Rx_AbortDetect, Rx_EoF, Rx_FrameError, ZeroDetect
  );
  modport slave (
    input  Rx, RxEN,
    output Rx_Data, Rx_NewByte, Rx_ValidFrame, Rx_FlagDetect,
           Rx_AbortDetect, Rx_EoF, Rx_FrameError, ZeroDetect
  );
endinterface

// File: rtl/rx_flag_window.sv
// 8-bit line window with per-bit data-valid mask; spots flag/abort patterns
// and presents the bit falling out of the window as the delayed data bit.
module rx_flag_window
  import hdlc_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic en,
  input  logic rx,
  input  logic in_frame,
  output logic exit_bit,
  output logic exit_vld,
  output logic is_flag,
  output logic is_abort
);
  logic [7:0] win, mask, win_nxt;

  assign win_nxt  = {win[6:0], rx};
  assign is_flag  = en && (win_nxt == FLAG);
  assign is_abort = en && (win_nxt == ABORT);
  assign exit_bit = win[7];
  assign exit_vld = en && mask[7];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      win  <= '0;
      mask <= '0;
    end else if (en) begin
      win <= win_nxt;
      // Bits that formed a flag/abort must never surface as data.
      // Outside a frame the mask is already empty, so clearing on abort is safe.
      mask <= (is_flag || is_abort) ? 8'h00 : {mask[6:0], in_frame};
    end
  end
endmodule

// File: rtl/rx_deframer.sv
// HDLC receive deframer: zero destuffing, byte assembly and frame delimiting.
module rx_deframer
  import hdlc_pkg::*;
(
  input  logic         Clk,
  input  logic         Rst,
  rx_deframer_if.slave bus
);
  state_t     state;
  logic [2:0] ones, cnt, ones_n, cnt_n;
  logic [7:0] asm_q, asm_n;
  logic       bytes, bytes_n, zd, nb;
  logic       exit_bit, exit_vld, is_flag, is_abort, en;

  assign en = bus.RxEN;

  rx_flag_window u_win (
    .Clk(Clk), .Rst(Rst), .en(en), .rx(bus.Rx), .in_frame(state == FRAME),
    .exit_bit(exit_bit), .exit_vld(exit_vld), .is_flag(is_flag), .is_abort(is_abort)
  );

  // Exit bit is handled first; flag/abort decisions see these updated counters.
  always_comb begin
    ones_n  = ones;
    cnt_n   = cnt;
    asm_n   = asm_q;
    bytes_n = bytes;
    zd      = 1'b0;
    nb      = 1'b0;
    if (exit_vld) begin
      if (!exit_bit && ones == 3'd5) begin
        ones_n = 3'd0;
        zd     = 1'b1;
      end else begin
        ones_n     = exit_bit ? ((ones == 3'd7) ? ones : ones + 3'd1) : 3'd0;
        asm_n[cnt] = exit_bit;
        if (cnt == 3'd7) begin
          nb      = 1'b1;
          bytes_n = 1'b1;
        end
        cnt_n = cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state              <= HUNT;
      ones               <= '0;
      cnt                <= '0;
      asm_q              <= '0;
      bytes              <= 1'b0;
      bus.Rx_Data        <= 8'h00;
      bus.Rx_NewByte     <= 1'b0;
      bus.Rx_ValidFrame  <= 1'b0;
      bus.Rx_FlagDetect  <= 1'b0;
      bus.Rx_AbortDetect <= 1'b0;
      bus.Rx_EoF         <= 1'b0;
      bus.Rx_FrameError  <= 1'b0;
      bus.ZeroDetect     <= 1'b0;
    end else begin
      bus.Rx_NewByte     <= 1'b0;
      bus.Rx_FlagDetect  <= 1'b0;
      bus.Rx_AbortDetect <= 1'b0;
      bus.Rx_EoF         <= 1'b0;
      bus.Rx_FrameError  <= 1'b0;
      bus.ZeroDetect     <= 1'b0;
      if (en) begin
        ones           <= ones_n;
        cnt            <= cnt_n;
        asm_q          <= asm_n;
        bytes          <= bytes_n;
        bus.ZeroDetect <= zd;
        bus.Rx_NewByte <= nb;
        if (nb) bus.Rx_Data <= asm_n;
        bus.Rx_FlagDetect <= is_flag;
        if (is_flag) begin
          // A closing flag doubles as the opening flag of the next frame.
          if (state == FRAME) begin
            bus.Rx_EoF        <= (cnt_n == 3'd0) && bytes_n;
            bus.Rx_FrameError <= (cnt_n != 3'd0);
          end
          state             <= FRAME;
          bus.Rx_ValidFrame <= 1'b1;
          cnt               <= '0;
          ones              <= '0;
          bytes             <= 1'b0;
        end else if (is_abort && state == FRAME) begin
          bus.Rx_AbortDetect <= 1'b1;
          state              <= HUNT;
          bus.Rx_ValidFrame  <= 1'b0;
          cnt                <= '0;
          ones               <= '0;
          bytes              <= 1'b0;
        end
      end
    end
  end
endmodule
